// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the boot-time instruction loader.
// Contents:
//   INSTR_W        - instruction word width
//   PC_W           - program counter / instruction-memory address width
//   loader_state_t - loader FSM state encoding
//   place_byte     - inserts one byte into a little-endian word
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_t;

  // Byte idx lands in bits [8*idx+7 : 8*idx] (little-endian assembly).
  function automatic logic [INSTR_W-1:0] place_byte(
    input logic [INSTR_W-1:0] word,
    input logic [1:0]         idx,
    input logic [7:0]         b
  );
    logic [INSTR_W-1:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-gap watchdog for the instruction loader.
// A down-counter reloaded to TIMEOUT-1 by clear; it counts down while run is
// high and raises expire once it has reached zero with run still high.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - reload the counter (byte accepted or new load started)
//   run       - count this cycle (loader is waiting for a byte)
//   expire    - idle budget used up
import cpu_pkg::*;

module loader_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Reload on clear, otherwise count down toward zero while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= LOAD_VAL;
    end else if (clear) begin
      cnt_r <= LOAD_VAL;
    end else if (run && (cnt_r != ZERO)) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Expiry decode from the counter register.
  always_comb begin
    expire = 1'b0;
    if (run && (cnt_r == ZERO)) begin
      expire = 1'b1;
    end else begin
      expire = 1'b0;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction-memory writer.
// Takes a byte stream (16-bit big-endian word count, then little-endian
// 32-bit words), writes each word to consecutive addresses and keeps the CPU
// in reset until the whole image is in memory.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   load_start        - start pulse (honoured in IDLE, DONE, ERR)
//   in_data/in_valid  - byte stream input, in_ready is the handshake reply
//   imem_addr/wdata/we- instruction-memory write port, one strobe per word
//   cpu_hold          - CPU reset, released only in DONE
//   done, error       - level status of the last load
//   words_loaded      - words written by the current or last load
import cpu_pkg::*;

module instr_loader #(
  parameter int ADDR_W    = PC_W,
  parameter int ADDR_STEP = 1,
  parameter int MAX_WORDS = 1024,
  parameter int TIMEOUT   = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               imem_we,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [15:0]        words_loaded
);

  localparam logic [15:0]       MAX_LEN   = 16'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  loader_state_t      state_r;
  logic [7:0]         len_hi_r;
  logic [15:0]        len_r;
  logic [INSTR_W-1:0] word_r;
  logic [1:0]         byte_idx_r;
  logic [ADDR_W-1:0]  imem_addr_r;
  logic [INSTR_W-1:0] imem_wdata_r;
  logic               imem_we_r;
  logic               cpu_hold_r;
  logic               done_r;
  logic               error_r;
  logic [15:0]        words_loaded_r;

  logic               in_ready_s;
  logic               accept_s;
  logic               start_s;
  logic               tmo_run_s;
  logic               tmo_clear_s;
  logic               tmo_expire_s;
  logic [15:0]        len_s;

  // State decode: byte handshake, watchdog enable and start qualification.
  always_comb begin
    in_ready_s = 1'b0;
    tmo_run_s  = 1'b0;
    start_s    = 1'b0;
    case (state_r)
      LEN_HI, LEN_LO, DATA: begin
        in_ready_s = 1'b1;
        tmo_run_s  = 1'b1;
      end
      IDLE, DONE, ERR: begin
        start_s = load_start;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
    accept_s    = in_valid && in_ready_s;
    tmo_clear_s = accept_s || start_s;
    len_s       = {len_hi_r, in_data};
  end

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear_s),
    .run    (tmo_run_s),
    .expire (tmo_expire_s)
  );

  // Loader FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      len_hi_r       <= 8'd0;
      len_r          <= 16'd0;
      word_r         <= 32'd0;
      byte_idx_r     <= 2'd0;
      imem_addr_r    <= ADDR_ZERO;
      imem_wdata_r   <= 32'd0;
      imem_we_r      <= 1'b0;
      cpu_hold_r     <= 1'b1;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      words_loaded_r <= 16'd0;
    end else begin
      imem_we_r <= 1'b0;
      if (start_s) begin
        state_r        <= LEN_HI;
        imem_addr_r    <= ADDR_ZERO;
        words_loaded_r <= 16'd0;
        byte_idx_r     <= 2'd0;
        word_r         <= 32'd0;
        cpu_hold_r     <= 1'b1;
        done_r         <= 1'b0;
        error_r        <= 1'b0;
      end else begin
        case (state_r)
          LEN_HI: begin
            if (accept_s) begin
              len_hi_r <= in_data;
              state_r  <= LEN_LO;
            end else if (tmo_expire_s) begin
              state_r <= ERR;
              error_r <= 1'b1;
            end
          end
          LEN_LO: begin
            if (accept_s) begin
              len_r <= len_s;
              if (len_s == 16'd0) begin
                state_r    <= DONE;
                done_r     <= 1'b1;
                cpu_hold_r <= 1'b0;
              end else if (len_s > MAX_LEN) begin
                state_r <= ERR;
                error_r <= 1'b1;
              end else begin
                state_r <= DATA;
              end
            end else if (tmo_expire_s) begin
              state_r <= ERR;
              error_r <= 1'b1;
            end
          end
          DATA: begin
            if (accept_s) begin
              if (byte_idx_r == 2'd3) begin
                imem_wdata_r <= place_byte(word_r, 2'd3, in_data);
                imem_we_r    <= 1'b1;
                byte_idx_r   <= 2'd0;
                state_r      <= WRITE;
              end else begin
                word_r     <= place_byte(word_r, byte_idx_r, in_data);
                byte_idx_r <= byte_idx_r + 2'd1;
              end
            end else if (tmo_expire_s) begin
              // Partial word is dropped; the next load starts clean.
              byte_idx_r <= 2'd0;
              state_r    <= ERR;
              error_r    <= 1'b1;
            end
          end
          WRITE: begin
            imem_addr_r    <= imem_addr_r + ADDR_INC;
            words_loaded_r <= words_loaded_r + 16'd1;
            if ((words_loaded_r + 16'd1) == len_r) begin
              state_r    <= DONE;
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end else begin
              state_r <= DATA;
            end
          end
          IDLE, DONE, ERR: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign imem_addr    = imem_addr_r;
  assign imem_wdata   = imem_wdata_r;
  assign imem_we      = imem_we_r;
  assign cpu_hold     = cpu_hold_r;
  assign done         = done_r;
  assign error        = error_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus pushes expected memory writes,
// an independent monitor pops and compares on every write strobe.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  instr_loader #(
    .ADDR_W    (16),
    .ADDR_STEP (1),
    .MAX_WORDS (1024),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .imem_we      (imem_we),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int checks      = 0;
  int passes      = 0;
  int writes_seen = 0;

  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] img_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && imem_we === 1'b1) begin
      writes_seen++;
      chk("in_ready_low_in_write", {31'd0, in_ready}, 32'd0);
      if (exp_addr_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", imem_addr, imem_wdata);
      end else begin
        chk("write_addr", {16'd0, imem_addr}, {16'd0, exp_addr_q.pop_front()});
        chk("write_data", imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int gap = 0;
    int w   = 0;
    bit got = 0;
    if (rnd) begin
      while (gap < 4 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        gap++;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!got && w < 40) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else w++;
    end
    if (!got) begin
      checks++;
      $display("FAIL byte_accept: in_ready stayed 0 for 40 cycles, byte 0x%0h", b);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] wd, input bit rnd);
    for (int k = 0; k < 4; k++) send_byte(wd[8*k +: 8], rnd);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!(done === 1'b1 || error === 1'b1)) begin
      checks++;
      $display("FAIL wait_end: neither done nor error after %0d cycles", n);
    end
  endtask

  // Reference: image of N words lands at addresses 0, STEP, 2*STEP, ...
  task automatic run_image(input bit rnd);
    logic [15:0] len;
    len = 16'(img_q.size());
    start_load();
    send_byte(len[15:8], rnd);
    send_byte(len[7:0], rnd);
    for (int i = 0; i < img_q.size(); i++) begin
      exp_addr_q.push_back(16'(i * 1));
      exp_data_q.push_back(img_q[i]);
      send_word(img_q[i], rnd);
    end
    in_valid = 1'b0;
    wait_end();
  endtask

  task automatic check_final(input string tag, input bit exp_done, input bit exp_err,
                             input logic [15:0] exp_words);
    chk({tag, "_done"},     {31'd0, done},      {31'd0, exp_done});
    chk({tag, "_error"},    {31'd0, error},     {31'd0, exp_err});
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold},  {31'd0, !exp_done});
    chk({tag, "_words"},    {16'd0, words_loaded}, {16'd0, exp_words});
    chk({tag, "_sb_empty"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    int wb;
    int n;
    rst        = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_imem_we",  {31'd0, imem_we},  32'd0);
    chk("rst_addr",     {16'd0, imem_addr}, 32'd0);
    chk("rst_wdata",    imem_wdata,        32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_error",    {31'd0, error},    32'd0);
    chk("rst_words",    {16'd0, words_loaded}, 32'd0);

    // Two-word image, back-to-back bytes.
    img_q = '{32'h0000_0013, 32'h0010_0093};
    run_image(1'b0);
    check_final("len2", 1'b1, 1'b0, 16'd2);

    // Zero-length image: straight to DONE, no writes.
    img_q.delete();
    wb = writes_seen;
    run_image(1'b0);
    check_final("len0", 1'b1, 1'b0, 16'd0);
    chk("len0_no_write", 32'(writes_seen), 32'(wb));

    // Length above the limit.
    wb = writes_seen;
    start_load();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    in_valid = 1'b0;
    wait_end();
    check_final("too_long", 1'b0, 1'b1, 16'd0);
    chk("too_long_no_write", 32'(writes_seen), 32'(wb));

    // Stall mid-word: error exactly after 16 idle cycles.
    wb = writes_seen;
    start_load();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 chk("timeout_not_yet", {31'd0, error}, 32'd0);
    @(posedge clk); #1;
    chk("timeout_error", {31'd0, error}, 32'd1);
    chk("timeout_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("timeout_no_write", 32'(writes_seen), 32'(wb));

    // Random valid gaps, fixed three-word image.
    img_q = '{32'hDEAD_BEEF, 32'h0123_4567, 32'hCAFE_F00D};
    run_image(1'b1);
    check_final("rand3", 1'b1, 1'b0, 16'd3);

    // Random images.
    for (int r = 0; r < 4; r++) begin
      img_q.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) img_q.push_back($urandom);
      run_image(1'b1);
      check_final("rand_img", 1'b1, 1'b0, 16'(n));
    end

    // Reset in the middle of the second word.
    start_load();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    exp_addr_q.push_back(16'd0);
    exp_data_q.push_back(32'h1111_2222);
    send_word(32'h1111_2222, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wb  = writes_seen;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("midrst_done",     {31'd0, done},     32'd0);
    chk("midrst_words",    {16'd0, words_loaded}, 32'd0);
    chk("midrst_addr",     {16'd0, imem_addr}, 32'd0);
    repeat (20) @(posedge clk);
    #1 chk("midrst_idle_no_write", 32'(writes_seen), 32'(wb));
    chk("midrst_sb_empty", 32'(exp_addr_q.size()), 32'd0);
    img_q = '{32'hA5A5_0F0F, 32'h5A5A_F0F0};
    run_image(1'b1);
    check_final("reload", 1'b1, 1'b0, 16'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
